// File: rtl/rv_en_dff_pkg.sv
// Shared definitions for the enabled flop: clock-gating mode selection.
package rv_en_dff_pkg;

  typedef enum logic {
    CG_NONE  = 1'b0,
    CG_LATCH = 1'b1
  } cg_mode_e;

  function automatic cg_mode_e cg_mode(input int unsigned gated);
    return (gated != 0) ? CG_LATCH : CG_NONE;
  endfunction

endpackage

// File: rtl/rv_en_dff_clk_gate.sv
// Latch-based glitch-free clock gate: enable is captured while clk is low.
module rv_clk_gate (
  input  logic clk,
  input  logic en,
  input  logic scan_mode,
  output logic l1clk
);

  logic en_lat;

  // Transparent while clk is low so the enable is stable for the whole high phase
  always_latch begin
    if (!clk) en_lat <= en | scan_mode;
  end

  assign l1clk = clk & en_lat;

endmodule

// File: rtl/rv_en_dff.sv
// Enabled register with optional latch-based clock gating and async active-low reset.
module rv_en_dff
  import rv_en_dff_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned GATED = 0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             scan_mode,
  output logic [WIDTH-1:0] dout
);

  localparam cg_mode_e CgMode = cg_mode(GATED);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next_c;

  // The en mux stays in the data path even when gated, so scan_mode never loads data
  always_comb begin
    q_next_c = q;
    q_next_c = en ? din : q;
  end

  if (CgMode == CG_LATCH) begin : g_gated
    logic l1clk;

    rv_clk_gate u_gate (
      .clk       (clk),
      .en        (en),
      .scan_mode (scan_mode),
      .l1clk     (l1clk)
    );

    // Reset bypasses the gate so it works while l1clk is stopped
    always_ff @(posedge l1clk or negedge rst_l) begin
      if (!rst_l) q <= '0;
      else        q <= q_next_c;
    end
  end else begin : g_plain
    logic unused_scan;
    assign unused_scan = scan_mode;

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) q <= '0;
      else        q <= q_next_c;
    end
  end

  assign dout = q;

endmodule

// File: tb/tb_rv_en_dff.sv
// Scoreboard bench for rv_en_dff: a 64-bit gated instance and a 1-bit plain instance.
module tb_rv_en_dff;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        en;
  logic        scan_mode;
  logic [63:0] din;
  logic [63:0] dout_g;
  logic [0:0]  dout_n;

  rv_en_dff #(.WIDTH(64), .GATED(1)) u_g (
    .clk       (clk),
    .rst_l     (rst_l),
    .en        (en),
    .din       (din),
    .scan_mode (scan_mode),
    .dout      (dout_g)
  );

  rv_en_dff #(.WIDTH(1), .GATED(0)) u_n (
    .clk       (clk),
    .rst_l     (rst_l),
    .en        (en),
    .din       (din[0:0]),
    .scan_mode (scan_mode),
    .dout      (dout_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] g;
    logic        n;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] ref_g;
  logic        ref_n;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          l1_cnt = 0;
  bit          armed = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: apply at negedge, advance the reference, queue the expectation
  task automatic drive(input logic e, input logic [63:0] d, input logic s, input bit glitch);
    @(negedge clk);
    en = e;
    din = d;
    scan_mode = s;
    if (e) begin
      ref_g = d;
      ref_n = d[0];
    end
    sb.push_back('{g: ref_g, n: ref_n});
    if (glitch) begin
      @(posedge clk);
      #1 en = ~e;
      #1 en = e;
      #1 en = ~e;
    end
  endtask

  // Monitor: every edge the registers present a new value; compare against the queue head
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("dout64", dout_g, e.g);
      chk("dout1", {63'b0, dout_n}, {63'b0, e.n});
    end
  end

  // Gated clock edges must coincide with clk edges (rise at t%10==5, fall at t%10==0)
  always @(posedge u_g.g_gated.u_gate.l1clk) begin
    l1_cnt++;
    if (armed) chk("l1clk_rise_align", 64'($time % 10), 64'd5);
  end

  always @(negedge u_g.g_gated.u_gate.l1clk) begin
    if (armed) chk("l1clk_fall_align", 64'($time % 10), 64'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_l = 1'b1;
    en = 1'b0;
    din = '0;
    scan_mode = 1'b0;
    ref_g = '0;
    ref_n = 1'b0;

    #1 rst_l = 1'b0;
    #1;
    chk("reset_dout64", dout_g, 64'h0);
    chk("reset_dout1", {63'b0, dout_n}, 64'h0);

    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    armed = 1'b1;

    // Single load then hold with din=0
    drive(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 64'h0, 1'b0, 1'b0);

    // Back-to-back loads
    drive(1'b1, 64'd1, 1'b0, 1'b0);
    drive(1'b1, 64'd2, 1'b0, 1'b0);
    drive(1'b1, 64'd3, 1'b0, 1'b0);

    // Async reset mid-cycle, held with en=1 and din all ones
    drive(1'b1, '1, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_l = 1'b0;
    #1;
    chk("async_rst_dout64", dout_g, 64'h0);
    chk("async_rst_dout1", {63'b0, dout_n}, 64'h0);
    ref_g = '0;
    ref_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      en = 1'b1;
      din = '1;
      scan_mode = 1'($urandom % 2);
      @(posedge clk);
      #1;
      chk("rst_hold_dout64", dout_g, 64'h0);
      chk("rst_hold_dout1", {63'b0, dout_n}, 64'h0);
    end
    @(negedge clk);
    en = 1'b0;
    rst_l = 1'b1;
    drive(1'b0, '1, 1'b0, 1'b0);

    // Scan mode opens the gate every cycle without loading data
    @(posedge clk);
    #2 l1_cnt = 0;
    repeat (4) drive(1'b0, {$urandom, $urandom}, 1'b1, 1'b0);
    @(posedge clk);
    #2 chk("scan_l1clk_pulses", 64'(l1_cnt), 64'd4);
    drive(1'b1, 64'h5, 1'b1, 1'b0);

    // Gate closed: no pulses
    @(posedge clk);
    #2 l1_cnt = 0;
    repeat (3) drive(1'b0, {$urandom, $urandom}, 1'b0, 1'b0);
    @(posedge clk);
    #2 chk("closed_l1clk_pulses", 64'(l1_cnt), 64'd0);

    // en toggled during clk-high phases must not create pulses or loads
    @(posedge clk);
    #2 l1_cnt = 0;
    for (int i = 0; i < 6; i++) drive(1'(i % 2), {$urandom, $urandom}, 1'b0, 1'b1);
    drive(1'b0, {$urandom, $urandom}, 1'b0, 1'b0);
    @(posedge clk);
    #2 chk("glitch_l1clk_pulses", 64'(l1_cnt), 64'd3);

    // Randomized traffic
    repeat (300)
      drive(1'($urandom % 2), {$urandom, $urandom}, 1'($urandom % 2), ($urandom % 4) == 0);
    drive(1'b0, 64'h0, 1'b0, 1'b0);

    @(posedge clk);
    #3 chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
